vdp_cmd_port: RTL and testbench

//  Z80-facing command/data port engine of the VDP. Sits directly downstream of vdp_port_decoder.
//  - Consumes that block's MODE/CSW_L/CSR_L/vdp_go strobes.
//  - Turns them into register-file writes, CRAM writes and handshaked VRAM reads/writes.
//  - Owns the two-byte control latch, 14-bit address pointer, 2-bit code register and read buffer.

---
 rtl/vdp_pkg.sv | 32 +++
 rtl/vdp_addr_ptr.sv | 50 +++++
 rtl/vdp_cmd_port.sv | 185 ++++++++++++++++++
 tb/tb_vdp_cmd_port.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// ============================================================================
//  Module      : vdp_pkg
//  Description : Shared types and constants for the VDP command/data port.
//                Command codes, port FSM states and the Z80 I/O port numbers.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package vdp_pkg;

    // Z80 I/O port numbers decoded upstream by vdp_port_decoder
    localparam logic [7:0] VDP_DATA_PORT = 8'hBE;
    localparam logic [7:0] VDP_CTRL_PORT = 8'hBF;

    // Two-bit command code carried in bits [7:6] of the second control byte
    typedef enum logic [1:0] {
        CODE_VRAM_RD = 2'd0,
        CODE_VRAM_WR = 2'd1,
        CODE_REG_WR  = 2'd2,
        CODE_CRAM_WR = 2'd3
    } cmd_code_t;

    // Port engine states; only IDLE accepts a new access
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_VRAM  = 2'd1,
        RD_FETCH = 2'd2
    } cmd_state_t;

endpackage

`default_nettype wire

// File: rtl/vdp_addr_ptr.sv
// ============================================================================
//  Module      : vdp_addr_ptr
//  Description : VRAM/CRAM address pointer. Low byte and high bits are loaded
//                separately from the two control bytes; increments wrap
//                modulo 2**ADDR_W.
//  Ports       : clk, rst_L      clock / async active-low reset
//                i_load_lo       load o_addr[7:0] from i_data
//                i_load_hi       load o_addr[ADDR_W-1:8] from i_data low bits
//                i_inc           o_addr <= o_addr + 1
//                i_data[7:0]     load data
//                o_addr          current pointer
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module vdp_addr_ptr #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              i_load_lo,
    input  logic              i_load_hi,
    input  logic              i_inc,
    input  logic [7:0]        i_data,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_addr;

    // Loads only happen in IDLE and increments only on completion, so the
    // controls are never asserted together; the priority is just a safeguard.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_addr <= '0;
        end else if (i_load_lo) begin
            r_addr[7:0] <= i_data;
        end else if (i_load_hi) begin
            r_addr[ADDR_W-1:8] <= i_data[ADDR_W-9:0];
        end else if (i_inc) begin
            r_addr <= r_addr + c_one;
        end
    end

    assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/vdp_cmd_port.sv
// ============================================================================
//  Module      : vdp_cmd_port
//  Description : Z80-facing command/data port engine of the VDP. Converts one
//                decoder access into a register write, CRAM write or a
//                handshaked VRAM read/write. Owns the two-byte control latch,
//                address pointer, command code and read buffer.
//  Ports       : clk, rst_L                  clock / async active-low reset
//                MODE, CSW_L, CSR_L, vdp_go  decoder strobes (1 = control)
//                data_in / data_out          Z80 bus in / read buffer out
//                int_ack                     pulse on status (control) read
//                rf_addr, rf_data_in, rf_en  register file write
//                vram_addr/wdata/re/we       VRAM request, held until ack
//                vram_ack, vram_rdata        VRAM completion / read data
//                cram_addr/wdata/we          CRAM write
//                code                        current command code
//                overrun                     pulse: access while busy
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module vdp_cmd_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int CRAM_AW  = 5,
    parameter int NUM_REGS = 11
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               MODE,
    input  logic               CSW_L,
    input  logic               CSR_L,
    input  logic               vdp_go,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               int_ack,
    output logic [3:0]         rf_addr,
    output logic [7:0]         rf_data_in,
    output logic               rf_en,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_re,
    output logic               vram_we,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [5:0]         cram_wdata,
    output logic               cram_we,
    output logic [1:0]         code,
    output logic               overrun
);

    localparam logic [4:0] c_num_regs = 5'(NUM_REGS);

    cmd_state_t r_state, w_state_nx;
    cmd_code_t  r_code;
    logic       r_go_q;
    logic       r_first;
    logic [7:0] r_rbuf;

    logic [ADDR_W-1:0] w_addr;
    cmd_code_t         w_new_code;
    logic w_strobe, w_wr, w_rd, w_act, w_idle, w_take;
    logic w_ctrl_lo, w_ctrl_hi, w_ctrl_rd, w_data_wr, w_data_rd;
    logic w_cram_wr, w_ack, w_inc, w_reg_wr;

    // vdp_go is held for two cycles; act only on its rising edge.
    assign w_strobe   = vdp_go & ~r_go_q;
    assign w_wr       = ~CSW_L;
    assign w_rd       = ~CSR_L & CSW_L;
    assign w_act      = w_strobe & (w_wr | w_rd);
    assign w_idle     = (r_state == IDLE);
    assign w_take     = w_act & w_idle;

    assign w_ctrl_lo  = w_take &  MODE & w_wr &  r_first;
    assign w_ctrl_hi  = w_take &  MODE & w_wr & ~r_first;
    assign w_ctrl_rd  = w_take &  MODE & w_rd;
    assign w_data_wr  = w_take & ~MODE & w_wr;
    assign w_data_rd  = w_take & ~MODE & w_rd;

    assign w_new_code = cmd_code_t'(data_in[7:6]);
    assign w_reg_wr   = w_ctrl_hi & (w_new_code == CODE_REG_WR);
    assign w_cram_wr  = w_data_wr & (r_code == CODE_CRAM_WR);
    // An ack arriving while IDLE belongs to nobody and is dropped.
    assign w_ack      = vram_ack & ~w_idle;
    assign w_inc      = w_ack | w_cram_wr;

    vdp_addr_ptr #(
        .ADDR_W (ADDR_W)
    ) u_addr_ptr (
        .clk       (clk),
        .rst_L     (rst_L),
        .i_load_lo (w_ctrl_lo),
        .i_load_hi (w_ctrl_hi),
        .i_inc     (w_inc),
        .i_data    (data_in),
        .o_addr    (w_addr)
    );

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if ((w_ctrl_hi && w_new_code == CODE_VRAM_RD) || w_data_rd) begin
                    w_state_nx = RD_FETCH;
                end else if (w_data_wr && r_code != CODE_CRAM_WR) begin
                    w_state_nx = WR_VRAM;
                end
            end
            WR_VRAM, RD_FETCH: begin
                if (vram_ack) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_go_q     <= 1'b0;
            r_first    <= 1'b1;
            r_code     <= CODE_VRAM_RD;
            r_rbuf     <= 8'h00;
            rf_addr    <= 4'h0;
            rf_data_in <= 8'h00;
            rf_en      <= 1'b0;
            cram_addr  <= '0;
            cram_wdata <= 6'h00;
            cram_we    <= 1'b0;
            vram_wdata <= 8'h00;
            int_ack    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_go_q  <= vdp_go;
            int_ack <= w_ctrl_rd;
            overrun <= w_act & ~w_idle;
            rf_en   <= w_reg_wr & ({1'b0, data_in[3:0]} < c_num_regs);
            cram_we <= w_cram_wr;

            // Any accepted access except the first control byte re-arms the
            // control latch, so a stray byte never pairs with a later one.
            if (w_take) begin
                r_first <= ~w_ctrl_lo;
            end
            if (w_ctrl_hi) begin
                r_code <= w_new_code;
            end
            if (w_reg_wr) begin
                rf_addr    <= data_in[3:0];
                rf_data_in <= w_addr[7:0];
            end
            if (w_cram_wr) begin
                cram_addr  <= w_addr[CRAM_AW-1:0];
                cram_wdata <= data_in[5:0];
            end
            if (w_data_wr && r_code != CODE_CRAM_WR) begin
                vram_wdata <= data_in;
            end
            // Data writes also land in the read buffer (SMS VDP behaviour).
            if (w_data_wr) begin
                r_rbuf <= data_in;
            end else if (w_ack && r_state == RD_FETCH) begin
                r_rbuf <= vram_rdata;
            end
        end
    end

    assign vram_we   = (r_state == WR_VRAM);
    assign vram_re   = (r_state == RD_FETCH);
    assign vram_addr = w_addr;
    assign data_out  = r_rbuf;
    assign code      = r_code;

endmodule

`default_nettype wire

// File: tb/tb_vdp_cmd_port.sv
// ============================================================================
//  Module      : tb_vdp_cmd_port
//  Description : Self-checking bench for vdp_cmd_port. Control-port vectors
//                from a table, hand sequences for VRAM/CRAM/overrun/reset,
//                and a scoreboard of expected VRAM/RF/CRAM transactions.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vdp_cmd_port;

    logic        clk = 1'b0;
    logic        rst_L, MODE, CSW_L, CSR_L, vdp_go, vram_ack;
    logic [7:0]  data_in, vram_rdata;
    logic [7:0]  data_out, rf_data_in, vram_wdata;
    logic [3:0]  rf_addr;
    logic [13:0] vram_addr;
    logic [4:0]  cram_addr;
    logic [5:0]  cram_wdata;
    logic [1:0]  code;
    logic        int_ack, rf_en, vram_re, vram_we, cram_we, overrun;

    always #5 clk = ~clk;

    vdp_cmd_port dut (
        .clk(clk), .rst_L(rst_L), .MODE(MODE), .CSW_L(CSW_L), .CSR_L(CSR_L),
        .vdp_go(vdp_go), .data_in(data_in), .data_out(data_out),
        .int_ack(int_ack), .rf_addr(rf_addr), .rf_data_in(rf_data_in),
        .rf_en(rf_en), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_re(vram_re), .vram_we(vram_we), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .cram_addr(cram_addr),
        .cram_wdata(cram_wdata), .cram_we(cram_we), .code(code),
        .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- scoreboard and reference model ----------------
    typedef struct { logic is_wr; logic [13:0] a; logic [7:0] d; } vexp_t;
    typedef struct { logic [3:0] a; logic [7:0] d; } rfexp_t;
    typedef struct { logic [4:0] a; logic [5:0] d; } cexp_t;
    vexp_t  vq[$];
    rfexp_t rq[$];
    cexp_t  cq[$];

    logic [7:0]  mem [0:16383];
    logic [13:0] m_addr;
    logic [1:0]  m_code;
    logic        m_first;
    logic [7:0]  m_rbuf;
    bit          ack_hold = 1'b0;
    int          ack_delay = 3;
    logic        s_rf_en, s_int_ack;

    task automatic reset_model();
        m_addr = '0; m_code = '0; m_first = 1'b1; m_rbuf = 8'h00;
        vq.delete(); rq.delete(); cq.delete();
    endtask

    // VRAM arbiter: acks ack_delay cycles after the request appears.
    initial begin
        int cnt;
        vexp_t e;
        cnt = 0; vram_ack = 1'b0; vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            vram_ack = 1'b0;
            if (vram_we || vram_re) begin
                cnt++;
                if (cnt >= ack_delay && !ack_hold) begin
                    if (vq.size() == 0) begin
                        fail("vram_unexpected");
                    end else begin
                        e = vq.pop_front();
                        check("vram_we", vram_we, e.is_wr);
                        check("vram_re", vram_re, !e.is_wr);
                        check("vram_addr", vram_addr, e.a);
                        if (e.is_wr) check("vram_wdata", vram_wdata, e.d);
                    end
                    if (vram_we) mem[vram_addr] = vram_wdata;
                    else         vram_rdata = mem[vram_addr];
                    vram_ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // RF / CRAM strobe monitor
    initial begin
        rfexp_t r;
        cexp_t  c;
        forever begin
            @(negedge clk);
            if (rf_en === 1'b1) begin
                if (rq.size() == 0) fail("rf_unexpected");
                else begin
                    r = rq.pop_front();
                    check("rf_addr", rf_addr, r.a);
                    check("rf_data_in", rf_data_in, r.d);
                end
            end
            if (cram_we === 1'b1) begin
                if (cq.size() == 0) fail("cram_unexpected");
                else begin
                    c = cq.pop_front();
                    check("cram_addr", cram_addr, c.a);
                    check("cram_wdata", cram_wdata, c.d);
                end
            end
            if (vram_we === 1'b1 && vram_re === 1'b1) fail("re_we_both");
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((vram_we || vram_re) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("idle_timeout");
    endtask

    // One decoder access: vdp_go high for two cycles; model updated at drive.
    task automatic access(input bit mode, input bit wr, input logic [7:0] d, input bit nowait = 1'b0);
        logic [7:0] rb_old;
        @(negedge clk);
        rb_old = m_rbuf;
        MODE = mode; CSW_L = ~wr; CSR_L = wr; data_in = d; vdp_go = 1'b1;
        m_first = 1'b1;
        if (mode && wr) begin
            if (rb_old === rb_old && m_first_was_set(d)) begin end
        end else if (!mode) begin
            if (wr) begin
                m_rbuf = d;
                if (m_code == 2'd3) cq.push_back('{m_addr[4:0], d[5:0]});
                else                vq.push_back('{1'b1, m_addr, d});
                m_addr++;
            end else begin
                vq.push_back('{1'b0, m_addr, 8'h00});
                m_rbuf = mem[m_addr];
                m_addr++;
            end
        end
        @(negedge clk);
        s_rf_en = rf_en; s_int_ack = int_ack;
        check("overrun_idle", overrun, 1'b0);
        if (!mode && !wr) check("rd_data_out", data_out, rb_old);
        @(negedge clk);
        vdp_go = 1'b0; CSW_L = 1'b1; CSR_L = 1'b1;
        check("pulse_width", {rf_en, int_ack, cram_we, overrun}, 4'h0);
        if (!nowait) wait_idle();
    endtask

    // Control-write model step; returns 1 so it can sit inside a condition.
    logic m_ctrl_first;
    function automatic bit m_first_was_set(input logic [7:0] d);
        if (m_ctrl_first) begin
            m_addr[7:0] = d;
            m_ctrl_first = 1'b0;
        end else begin
            m_addr[13:8] = d[5:0];
            m_code = d[7:6];
            m_ctrl_first = 1'b1;
            if (m_code == 2'd2 && d[3:0] < 4'd11) rq.push_back('{d[3:0], m_addr[7:0]});
            if (m_code == 2'd0) begin
                vq.push_back('{1'b0, m_addr, 8'h00});
                m_rbuf = mem[m_addr];
                m_addr++;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] all_outs();
        return {3'b0, data_out, int_ack, rf_addr, rf_data_in, rf_en, vram_addr,
                vram_wdata, vram_re, vram_we, cram_addr, cram_wdata, cram_we,
                code, overrun};
    endfunction

    typedef struct {
        bit mode; bit wr; logic [7:0] d;
        logic [13:0] e_addr; logic [1:0] e_code; bit e_int; bit e_rf;
    } vec_t;
    vec_t vt[10];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1'b1, 8'h34, 14'h0034, 2'd0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 8'h92, 14'h1234, 2'd2, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b1, 8'h99, 14'h1299, 2'd2, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 8'h00, 14'h1299, 2'd2, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 8'h05, 14'h1205, 2'd2, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 8'h81, 14'h0105, 2'd2, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 8'h77, 14'h0177, 2'd2, 1'b0, 1'b0};
        vt[7] = '{1'b1, 1'b1, 8'h8C, 14'h0C77, 2'd2, 1'b0, 1'b0};
        vt[8] = '{1'b1, 1'b1, 8'h10, 14'h0C10, 2'd2, 1'b0, 1'b0};
        vt[9] = '{1'b1, 1'b1, 8'h7F, 14'h3F10, 2'd1, 1'b0, 1'b0};

        for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
        reset_model();
        m_ctrl_first = 1'b1;
        rst_L = 1'b0; MODE = 1'b0; CSW_L = 1'b1; CSR_L = 1'b1;
        vdp_go = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'h0);
        rst_L = 1'b1;

        // Control-port table (register writes, status read, latch re-arm)
        for (int i = 0; i < 10; i++) begin
            if (vt[i].mode && !vt[i].wr) m_ctrl_first = 1'b1;
            access(vt[i].mode, vt[i].wr, vt[i].d);
            check($sformatf("vec%0d_addr", i), vram_addr, vt[i].e_addr);
            check($sformatf("vec%0d_code", i), code, vt[i].e_code);
            check($sformatf("vec%0d_int_ack", i), s_int_ack, vt[i].e_int);
            check($sformatf("vec%0d_rf_en", i), s_rf_en, vt[i].e_rf);
        end

        // VRAM writes with auto-increment
        access(1'b1, 1'b1, 8'h00);
        access(1'b1, 1'b1, 8'h40);
        m_ctrl_first = 1'b1;
        access(1'b0, 1'b1, 8'hAA);
        access(1'b0, 1'b1, 8'hBB);
        check("wr_final_addr", vram_addr, 14'h0002);

        // Read setup at the top of VRAM, pointer wrap, then data read
        access(1'b1, 1'b1, 8'hFF);
        access(1'b1, 1'b1, 8'h3F);
        check("prefetch_rbuf", data_out, 8'hA5);
        check("prefetch_wrap", vram_addr, 14'h0000);
        check("prefetch_code", code, 2'd0);
        access(1'b0, 1'b0, 8'h00);
        check("read_refill", data_out, 8'hAA);
        check("read_addr", vram_addr, 14'h0001);

        // CRAM writes, including CRAM address wrap at 0x20
        access(1'b1, 1'b1, 8'h1F);
        access(1'b1, 1'b1, 8'hC0);
        access(1'b0, 1'b1, 8'h3C);
        check("cram_addr_inc", vram_addr, 14'h0020);
        check("cram_code", code, 2'd3);
        check("cram_rbuf", data_out, 8'h3C);
        access(1'b0, 1'b1, 8'h15);
        check("cram_addr_inc2", vram_addr, 14'h0021);

        // Stalled write, overrun, async reset mid-wait
        access(1'b1, 1'b1, 8'h00);
        access(1'b1, 1'b1, 8'h40);
        ack_hold = 1'b1;
        access(1'b0, 1'b1, 8'h11, 1'b1);
        repeat (3) @(negedge clk);
        check("stall_we_high", vram_we, 1'b1);
        MODE = 1'b0; CSW_L = 1'b0; CSR_L = 1'b1; data_in = 8'h22; vdp_go = 1'b1;
        @(negedge clk);
        check("overrun_pulse", overrun, 1'b1);
        check("overrun_we_held", vram_we, 1'b1);
        check("overrun_wdata_kept", vram_wdata, 8'h11);
        @(negedge clk);
        vdp_go = 1'b0; CSW_L = 1'b1;
        check("overrun_1cyc", overrun, 1'b0);
        repeat (5) @(negedge clk);
        check("stall_addr_held", vram_addr, 14'h0000);
        #2 rst_L = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 64'h0);
        reset_model();
        m_ctrl_first = 1'b1;
        ack_hold = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        access(1'b1, 1'b1, 8'h12);
        check("post_reset_lo", vram_addr, 14'h0012);
        check("post_reset_code", code, 2'd0);

        repeat (4) @(negedge clk);
        check("vq_empty", vq.size(), 0);
        check("rq_empty", rq.size(), 0);
        check("cq_empty", cq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
